// File: rtl/axis_word_to_symbol_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_word_to_symbol_streamer_if
// Brief    : AXI4-Stream bundle (tdata/tlast/tvalid/tready, optional tkeep)
//            with master/slave modports for the word-to-symbol streamer.
//            tkeep and KEEP_WIDTH exist only when WTS_TKEEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_word_to_symbol_streamer_if #(
  parameter int DATA_WIDTH = 32
`ifdef WTS_TKEEP_EN
  , parameter int KEEP_WIDTH = 4
`endif
);
  logic [DATA_WIDTH-1:0] tdata;
`ifdef WTS_TKEEP_EN
  logic [KEEP_WIDTH-1:0] tkeep;
`endif
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
`ifdef WTS_TKEEP_EN
    output tkeep,
`endif
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
`ifdef WTS_TKEEP_EN
    input  tkeep,
`endif
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_word_to_symbol_streamer.sv
`default_nettype none
// ============================================================================
// Module   : axis_word_to_symbol_streamer
// Brief    : Serialises IN_WIDTH-bit AXI4-Stream words into OUT_WIDTH-bit
//            symbols through a one-word holding register with early ready,
//            sustaining one symbol per clock across word boundaries.
//            Optional per-symbol keep (skip + null-tlast error) is enabled
//            with the WTS_TKEEP_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module axis_word_to_symbol_streamer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int LSB_FIRST = 1,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic                       ACLK,
  input  wire logic                       ARESETN,
  axis_word_to_symbol_streamer_if.slave   s_axis,
  axis_word_to_symbol_streamer_if.master  m_axis,
  output logic [CNT_WIDTH-1:0]            frame_count,
  output logic                            err_null_last
);

  localparam int N     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // The held word is stored already permuted into emission order, so slot 0
  // is always the first symbol out regardless of LSB_FIRST. r_pend marks the
  // slots still to be emitted; its lowest set bit is the current symbol.
  state_t                             r_state,  w_state_nxt;
  logic [N-1:0][OUT_WIDTH-1:0]        r_slots,  w_slots_nxt;
  logic [N-1:0]                       r_pend,   w_pend_nxt;
  logic                               r_last,   w_last_nxt;
  logic [CNT_WIDTH-1:0]               r_cnt,    w_cnt_nxt;

  logic [N-1:0][OUT_WIDTH-1:0]        w_in_slots;
  logic [N-1:0]                       w_in_keep;
  logic                               w_in_null;
  logic [IDX_W-1:0]                   w_idx;
  logic                               w_last_sym;
  logic                               w_in_rdy;
  logic                               w_in_hs;
  logic                               w_out_hs;

  // Permute the incoming word and keep mask into emission order.
  for (genvar k = 0; k < N; k++) begin : g_slot
    localparam int SRC = (LSB_FIRST != 0) ? k : (N - 1 - k);
    assign w_in_slots[k] = s_axis.tdata[SRC*OUT_WIDTH +: OUT_WIDTH];
`ifdef WTS_TKEEP_EN
    assign w_in_keep[k]  = s_axis.tkeep[SRC];
`else
    assign w_in_keep[k]  = 1'b1;
`endif
  end

  assign w_in_null = (w_in_keep == '0);

  // Priority search: first pending slot in emission order.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_idx = IDX_W'(i);
    end
  end

  // Current symbol is the word's last when only one pending bit remains.
  assign w_last_sym = ((r_pend & (r_pend - N'(1))) == '0);

  // Early ready lets the next word load on the same edge the last symbol leaves.
  assign w_in_rdy = (r_state == ST_EMPTY) | (m_axis.tready & w_last_sym);
  assign w_in_hs  = s_axis.tvalid & w_in_rdy;
  assign w_out_hs = (r_state == ST_SHIFT) & m_axis.tready;

  assign s_axis.tready = ARESETN & w_in_rdy;
  assign m_axis.tvalid = (r_state == ST_SHIFT);
  assign m_axis.tdata  = (r_state == ST_SHIFT) ? r_slots[w_idx] : '0;
  assign m_axis.tlast  = (r_state == ST_SHIFT) & r_last & w_last_sym;
`ifdef WTS_TKEEP_EN
  assign m_axis.tkeep  = '1;
`endif
  assign frame_count   = r_cnt;

  // Next-state: retire the emitted symbol, then let an input handshake reload.
  always_comb begin
    w_state_nxt = r_state;
    w_slots_nxt = r_slots;
    w_pend_nxt  = r_pend;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    if (w_out_hs) begin
      w_pend_nxt = r_pend & (r_pend - N'(1));
      if (w_last_sym) w_state_nxt = ST_EMPTY;
      if (m_axis.tlast) w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
    // A word with no kept symbols is swallowed and leaves the FSM empty.
    if (w_in_hs && !w_in_null) begin
      w_state_nxt = ST_SHIFT;
      w_slots_nxt = w_in_slots;
      w_pend_nxt  = w_in_keep;
      w_last_nxt  = s_axis.tlast;
    end
  end

  // State and holding-register update; reset discards any partial word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_EMPTY;
      r_slots <= '0;
      r_pend  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slots <= w_slots_nxt;
      r_pend  <= w_pend_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef WTS_TKEEP_EN
  logic r_err;

  // One-cycle flag for a frame end lost inside an all-zero-keep word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_err <= 1'b0;
    else          r_err <= w_in_hs & w_in_null & s_axis.tlast;
  end

  assign err_null_last = r_err;
`else
  assign err_null_last = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_word_to_symbol_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_word_to_symbol_streamer
// Brief    : Self-checking bench for axis_word_to_symbol_streamer. Drives an
//            LSB-first and an MSB-first instance with identical stimulus.
//            Keep-specific sequences are compiled in with WTS_TKEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_word_to_symbol_streamer;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int CW = 16;

  logic tb_ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  axis_word_to_symbol_streamer_if #(
    .DATA_WIDTH(IW)
`ifdef WTS_TKEEP_EN
    , .KEEP_WIDTH(4)
`endif
  ) s0 ();
  axis_word_to_symbol_streamer_if #(
    .DATA_WIDTH(IW)
`ifdef WTS_TKEEP_EN
    , .KEEP_WIDTH(4)
`endif
  ) s1 ();
  axis_word_to_symbol_streamer_if #(
    .DATA_WIDTH(OW)
`ifdef WTS_TKEEP_EN
    , .KEEP_WIDTH(1)
`endif
  ) m0 ();
  axis_word_to_symbol_streamer_if #(
    .DATA_WIDTH(OW)
`ifdef WTS_TKEEP_EN
    , .KEEP_WIDTH(1)
`endif
  ) m1 ();

  assign s1.tdata  = s0.tdata;
  assign s1.tlast  = s0.tlast;
  assign s1.tvalid = s0.tvalid;
`ifdef WTS_TKEEP_EN
  assign s1.tkeep  = s0.tkeep;
`endif
  assign m1.tready = m0.tready;

  logic [CW-1:0] fc0, fc1;
  logic          err0, err1;

  axis_word_to_symbol_streamer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1), .CNT_WIDTH(CW)) dut0 (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .s_axis(s0), .m_axis(m0),
    .frame_count(fc0), .err_null_last(err0));

  axis_word_to_symbol_streamer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(0), .CNT_WIDTH(CW)) dut1 (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .s_axis(s1), .m_axis(m1),
    .frame_count(fc1), .err_null_last(err1));

  // Directed vectors: byte j of *_seq is the j-th symbol expected out.
  typedef struct packed {
    logic [31:0] word;
    logic        last;
    logic [31:0] lsb_seq;
    logic [31:0] msb_seq;
  } vec_t;
  vec_t vecs [4];

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } sym_t;

  sym_t        q0[$];
  sym_t        q1[$];
  logic [15:0] exp_fc   = '0;
  logic        pend_err = 1'b0;
  logic        stall0   = 1'b0;
  logic [7:0]  stall_d  = '0;
  logic        stall_l  = 1'b0;
  logic        s_hs     = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the kept bytes of a word, in ascending byte position,
  // emitted forwards by the LSB-first unit and backwards by the MSB-first one.
  task automatic model_push(input logic [31:0] w, input logic [3:0] kp, input logic lst);
    logic [7:0] kept[$];
    sym_t s;
    for (int i = 0; i < 4; i++) if (kp[i]) kept.push_back(w[i*8 +: 8]);
    for (int i = 0; i < kept.size(); i++) begin
      s.d = kept[i]; s.l = lst && (i == kept.size() - 1); q0.push_back(s);
    end
    for (int i = kept.size() - 1; i >= 0; i--) begin
      s.d = kept[i]; s.l = lst && (i == 0); q1.push_back(s);
    end
  endtask

  task automatic monitor();
    logic [3:0] kp;
    sym_t e;
    s_hs = 1'b0;
    if (!ARESETN) return;
    chk("frame_count0", fc0, exp_fc);
    chk("frame_count1", fc1, exp_fc);
    chk("err_null_last0", err0, pend_err);
    chk("err_null_last1", err1, pend_err);
    if (stall0) begin
      chk("stall_valid", m0.tvalid, 1);
      chk("stall_data", m0.tdata, stall_d);
      chk("stall_last", m0.tlast, stall_l);
    end
    stall0 = m0.tvalid && !m0.tready;
    stall_d = m0.tdata;
    stall_l = m0.tlast;
    if (m0.tvalid && m0.tready) begin
      if (q0.size() == 0) chk("unexpected_sym0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("sym0", m0.tdata, e.d);
        chk("last0", m0.tlast, e.l);
        if (e.l) exp_fc++;
      end
    end
    if (m1.tvalid && m1.tready) begin
      if (q1.size() == 0) chk("unexpected_sym1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("sym1", m1.tdata, e.d);
        chk("last1", m1.tlast, e.l);
      end
    end
`ifdef WTS_TKEEP_EN
    kp = s0.tkeep;
`else
    kp = 4'hF;
`endif
    pend_err = 1'b0;
    if (s0.tvalid && s0.tready) begin
      s_hs = 1'b1;
      model_push(s0.tdata, kp, s0.tlast);
      pend_err = (kp == 4'h0) && s0.tlast;
    end
  endtask

  task automatic wait_neg();
    @(negedge tb_ACLK);
    monitor();
  endtask

  task automatic to_post();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic cycle();
    wait_neg();
    to_post();
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] kp, input logic lst);
    s0.tdata = w; s0.tlast = lst; s0.tvalid = 1'b1;
`ifdef WTS_TKEEP_EN
    s0.tkeep = kp;
`else
    if (kp != 4'hF) $display("note: keep ignored in this build");
`endif
    wait_neg();
    chk("send_ready", s0.tready, 1);
    to_post();
    s0.tvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] bb;
    logic [31:0] rs;
    int idx;
    int cyc;

    vecs[0] = '{32'hDEAD0011, 1'b1, 32'hDEAD0011, 32'h1100ADDE};
    vecs[1] = '{32'h12345678, 1'b0, 32'h12345678, 32'h78563412};
    vecs[2] = '{32'hA5C30F96, 1'b1, 32'hA5C30F96, 32'h960FC3A5};
    vecs[3] = '{32'hFFFF0000, 1'b1, 32'hFFFF0000, 32'h0000FFFF};

    s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0; m0.tready = 1'b0;
`ifdef WTS_TKEEP_EN
    s0.tkeep = 4'hF;
`endif
    ARESETN = 1'b0;
    repeat (2) @(posedge tb_ACLK);
    #1;
    chk("rst_valid", m0.tvalid, 0);
    chk("rst_data", m0.tdata, 0);
    chk("rst_last", m0.tlast, 0);
    chk("rst_in_ready", s0.tready, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_err", err0, 0);
    ARESETN = 1'b1;
    wait_neg();
    chk("empty_in_ready", s0.tready, 1);
    chk("empty_valid", m0.tvalid, 0);
    to_post();

    // Table-driven single words, full-rate downstream.
    m0.tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].word, 4'hF, vecs[v].last);
      for (int j = 0; j < 4; j++) begin
        wait_neg();
        chk("tbl_valid", m0.tvalid, 1);
        chk("tbl_data_lsb", m0.tdata, vecs[v].lsb_seq[j*8 +: 8]);
        chk("tbl_data_msb", m1.tdata, vecs[v].msb_seq[j*8 +: 8]);
        chk("tbl_last_lsb", m0.tlast, vecs[v].last && (j == 3));
        chk("tbl_last_msb", m1.tlast, vecs[v].last && (j == 3));
        chk("tbl_early_ready0", s0.tready, j == 3);
        chk("tbl_early_ready1", s1.tready, j == 3);
        to_post();
      end
      wait_neg();
      chk("tbl_idle", m0.tvalid, 0);
      to_post();
    end
    chk("fc_after_table", fc0, 3);

    // Back-to-back words with no bubble.
    bb = 64'hABCD0001_0101FFFF;
    s0.tdata = 32'h0101FFFF; s0.tlast = 1'b0; s0.tvalid = 1'b1;
    wait_neg();
    to_post();
    s0.tdata = 32'hABCD0001; s0.tlast = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wait_neg();
      chk("b2b_valid", m0.tvalid, 1);
      chk("b2b_data", m0.tdata, bb[j*8 +: 8]);
      chk("b2b_last", m0.tlast, j == 7);
      chk("b2b_in_ready", s0.tready, (j == 3) || (j == 7));
      to_post();
      if (j == 3) s0.tvalid = 1'b0;
    end
    wait_neg();
    chk("b2b_idle", m0.tvalid, 0);
    to_post();

`ifdef WTS_TKEEP_EN
    // Sparse keep: only bytes 1 and 3 survive.
    send_word(32'hBEEF0011, 4'b1010, 1'b1);
    wait_neg();
    chk("keep_d0", m0.tdata, 8'h00); chk("keep_l0", m0.tlast, 0);
    chk("keep_msb_d0", m1.tdata, 8'hBE);
    chk("keep_tkeep", m0.tkeep, 1); chk("keep_tkeep1", m1.tkeep, 1);
    to_post();
    wait_neg();
    chk("keep_d1", m0.tdata, 8'hBE); chk("keep_l1", m0.tlast, 1);
    chk("keep_msb_d1", m1.tdata, 8'h00); chk("keep_ready1", s0.tready, 1);
    to_post();
    // All-zero keep with tlast: swallowed, error pulse, count unchanged.
    send_word(32'h12345678, 4'b0000, 1'b1);
    wait_neg();
    chk("null_err_pulse", err0, 1);
    chk("null_no_output", m0.tvalid, 0);
    to_post();
    wait_neg();
    chk("null_err_clear", err0, 0);
    chk("null_fc", fc0, 5);
    to_post();
    s0.tkeep = 4'hF;
`endif

    // Reset in the middle of a word.
    send_word(32'h0A0B0C0D, 4'hF, 1'b1);
    cycle();
    cycle();
    #2 ARESETN = 1'b0;
    #1;
    chk("midrst_valid", m0.tvalid, 0);
    chk("midrst_data", m0.tdata, 0);
    chk("midrst_last", m0.tlast, 0);
    chk("midrst_in_ready", s0.tready, 0);
    chk("midrst_fc", fc0, 0);
    chk("midrst_err", err0, 0);
    q0.delete(); q1.delete();
    exp_fc = '0; pend_err = 1'b0; stall0 = 1'b0;
    to_post();
    ARESETN = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_neg();
      chk("post_rst_idle", m0.tvalid, 0);
      to_post();
    end
    rs = 32'h44332211;
    send_word(rs, 4'hF, 1'b1);
    for (int j = 0; j < 4; j++) begin
      wait_neg();
      chk("post_rst_data", m0.tdata, rs[j*8 +: 8]);
      chk("post_rst_last", m0.tlast, j == 3);
      to_post();
    end

    // Randomized traffic with 50% downstream backpressure.
    idx = 0;
    cyc = 0;
    while (idx < 100 && cyc < 3000) begin
      if (!s0.tvalid && ($urandom_range(3) != 0)) begin
        s0.tdata = $urandom;
        s0.tlast = ($urandom_range(3) == 0);
`ifdef WTS_TKEEP_EN
        s0.tkeep = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15));
`endif
        s0.tvalid = 1'b1;
      end
      m0.tready = 1'($urandom_range(1));
      cycle();
      cyc++;
      if (s_hs) begin
        s0.tvalid = 1'b0;
        idx++;
      end
    end
    chk("rand_words_accepted", idx, 100);
    s0.tvalid = 1'b0;
    m0.tready = 1'b1;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < 100) begin
      cycle();
      cyc++;
    end
    chk("rand_drain0", q0.size(), 0);
    chk("rand_drain1", q1.size(), 0);
    cycle();
    cycle();
    chk("rand_idle", m0.tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axis_word_to_symbol_streamer.md
Name: axis_word_to_symbol_streamer

Overview:
Parametrised successor to the word-to-byte streamer. Accepts IN_WIDTH-bit AXI4-Stream words and serialises them into OUT_WIDTH-bit symbols on an AXI4-Stream master, with selectable symbol order and tlast propagation. A one-word holding register with early ready sustains one symbol per clock across word boundaries. Sits between a DMA/word-wide fabric and narrow symbol consumers (UART/SPI framers, CRC engines).

Parameters:
IN_WIDTH, 32, input word width in bits; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 8, output symbol width in bits.
LSB_FIRST, 1, 1: symbol 0 = bits [OUT_WIDTH-1:0] emitted first; 0: most-significant symbol first.
CNT_WIDTH, 16, width of the frame counter.

Ports:
ACLK  in  1  clock, all logic rising-edge.
ARESETN  in  1  asynchronous active-low reset.
s_axis_tdata  in  IN_WIDTH  input word.
s_axis_tkeep  in  N=IN_WIDTH/OUT_WIDTH  per-symbol keep (present only with WTS_TKEEP_EN).
s_axis_tlast  in  1  last word of frame.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
m_axis_tdata  out  OUT_WIDTH  output symbol.
m_axis_tlast  out  1  last symbol of frame.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
frame_count  out  CNT_WIDTH  count of tlast symbols emitted.
err_null_last  out  1  one-cycle pulse: tlast word dropped with all-zero keep.

Behaviour:
- Reset (ARESETN low, async): holding register empty, symbol index 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 while in reset, frame_count=0, err_null_last=0. Asserting reset mid-word discards the partial word; no symbol emitted after reset release until a new input handshake.
- States: EMPTY (no word held), SHIFT (word held, emitting symbols).
- EMPTY: s_axis_tready=1. On s_axis_tvalid -> load word, tlast and keep mask; index = first kept symbol in emission order; go to SHIFT. Output valid one cycle after input handshake (latency 1).
- SHIFT: m_axis_tvalid=1, m_axis_tdata = held word slice at index (order per LSB_FIRST). On m_axis_tready: advance index to next kept symbol.
- Last symbol of a word = no kept symbols remain after index. m_axis_tlast = held tlast AND last symbol.
- Early ready: in SHIFT, s_axis_tready = m_axis_tready AND last symbol. Simultaneous last-symbol output handshake and input handshake -> load new word directly, stay in SHIFT, no bubble. Last-symbol handshake without input -> EMPTY.
- Throughput: one symbol per clock sustained with continuous valid/ready; N cycles per full word.
- m_axis_tdata/tlast stable while tvalid=1 and tready=0 (AXI4-Stream rule); s_axis input never re-sampled in SHIFT except on the last-symbol handshake.
- frame_count increments by 1 on each output handshake with m_axis_tlast=1; wraps 2^CNT_WIDTH-1 -> 0.
- Combinational path m_axis_tready -> s_axis_tready is permitted and required for full rate.

Optional Feature:
Macro WTS_TKEEP_EN.
- Defined: s_axis_tkeep port exists; symbols with keep=0 are skipped (index jumps via priority search in emission order). A word with all-zero keep is consumed in one cycle, produces no output, and stays in/returns to EMPTY; if its tlast=1, err_null_last pulses for one cycle and frame_count is unchanged.
- Not defined: no s_axis_tkeep port; keep treated as all ones; err_null_last tied 0.

Test Plan:
- IN=32, OUT=8, LSB_FIRST=1, single word 0xDEAD0011 tlast=1, tready=1 -> symbols 0x11,0x00,0xAD,0xDE on 4 consecutive cycles, tlast only on 0xDE, frame_count=1.
- LSB_FIRST=0, same word -> 0xDE,0xAD,0x00,0x11, tlast on 0x11.
- Back-to-back 0x0101FFFF, 0xABCD0001 (tlast on second), tvalid/tready held high -> 8 symbols on 8 consecutive cycles, no bubble, s_axis_tready high on cycles 4 and 8 of output only.
- Random m_axis_tready backpressure (50%) over 100 words -> output sequence equals serialised input, tdata stable while stalled, frame_count matches tlast count.
- WTS_TKEEP_EN: word 0xBEEF0011 keep=4'b1010 tlast=1 -> 0x00, 0xBE (tlast); keep=4'b0000 tlast=1 -> no output, err_null_last pulse, frame_count unchanged.
- Assert ARESETN low after 2 of 4 symbols -> outputs at reset values immediately; after release, next word emits from symbol 0 with no residue.
